// File: rtl/fa_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry register,
// processing WIDTH operand bits LSB first, one bit per clock.
module fa_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_bit;
  logic             w_cnew;
  logic [WIDTH-1:0] w_res_nxt;

  // The single full-adder cell
  assign w_bit  = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cnew = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_nxt = w_bit;
    end else begin : g_res_wn
      assign w_res_nxt = {w_bit, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the borrow-in is folded into the carry
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= ci ^ sub;
            r_cnt   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnew;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // r_c still holds the carry into the MSB here
            s       <= w_res_nxt;
            co      <= w_cnew;
            ovf     <= r_c ^ w_cnew;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
